// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Both sides import the operation-code constants from here, so the encoding
// the decoder produces and the encoding the ALU consumes cannot drift apart.
//
// Contents:
//   XLEN_DEFAULT        default datapath width (64)
//   ALU_* constants     4-bit operation codes
//   ST_* constants      execute FSM state encodings
//   op_is_legal()       true for any code the ALU implements
//   op_is_iterative()   true for codes that take the multi-cycle path
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Operation codes produced by the ALU control decoder.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  // Execute FSM states. Kept as plain constants so older tools and the
  // existing waveform decoders keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only the left shift walks through the SHIFT state; everything else,
  // including illegal codes, completes in one registered cycle.
  function automatic logic op_is_iterative(input logic [3:0] op);
    return (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/ex_alu_comb.sv
// ---------------------------------------------------------------------------
// ex_alu_comb
// Purely combinational datapath for the single-cycle operations:
// add, sub, and, or. Illegal codes produce a zero result with the illegal
// flag set. The left shift is not handled here (the top iterates it), so
// for ALU_SLL this block returns zero and does not flag it as illegal.
//
// Ports:
//   op_code  in   4     operation code from the ALU control decoder
//   src_a    in   XLEN  operand A
//   src_b    in   XLEN  operand B
//   result   out  XLEN  combinational result
//   illegal  out  1     op_code is not one the ALU implements
// ---------------------------------------------------------------------------
module ex_alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      op_code,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  logic            sub_sel;
  logic [XLEN-1:0] b_in;
  logic [XLEN-1:0] carry_in;
  logic [XLEN-1:0] sum;

  // Add and sub share one adder: a - b is a + ~b + 1. The carry out is
  // simply dropped, which gives the modulo 2^XLEN behaviour.
  assign sub_sel  = (op_code == ALU_SUB);
  assign b_in     = sub_sel ? ~src_b : src_b;
  assign carry_in = {{(XLEN-1){1'b0}}, sub_sel};
  assign sum      = src_a + b_in + carry_in;

  always_comb begin
    result  = '0;
    illegal = !op_is_legal(op_code);
    case (op_code)
      ALU_ADD, ALU_SUB: result = sum;
      ALU_AND:          result = src_a & src_b;
      ALU_OR:           result = src_a | src_b;
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// ---------------------------------------------------------------------------
// ex_alu_unit
// Execute-stage ALU. Add, sub, and, or (and illegal codes) complete one
// cycle after accept. SLL is done one bit per cycle in a shift register,
// so an op with shift amount N presents its result N+1 cycles after accept
// (N=0 completes in one cycle). Valid/ready on both sides lets the hazard
// unit stall around the long shifts.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous reset, active-low
//   in_valid    in   1        op_code/src_a/src_b are valid
//   in_ready    out  1        unit can accept an op this cycle
//   op_code     in   4        operation code (see alu_pkg)
//   src_a       in   XLEN     operand A (rs1)
//   src_b       in   XLEN     operand B; low SHAMT_W bits are the sll amount
//   flush       in   1        drop any in-flight op (branch mispredict)
//   out_valid   out  1        result/zero/illegal_op are valid
//   out_ready   in   1        downstream takes the result this cycle
//   result      out  XLEN     registered result
//   zero        out  1        result == 0, registered with result
//   illegal_op  out  1        the completed op had an unsupported code
//
// All outputs come from registers or from state/out_ready, never from the
// operands, so there is no input-to-output path through the datapath.
// ---------------------------------------------------------------------------
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op_code,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  logic [1:0]         state;
  logic [XLEN-1:0]    shift_reg;
  logic [XLEN-1:0]    shift_next;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic               illegal_q;

  logic               accept;
  logic               is_shift;
  logic [XLEN-1:0]    comb_result;
  logic               comb_illegal;

  ex_alu_comb #(
    .XLEN (XLEN)
  ) u_comb (
    .op_code (op_code),
    .src_a   (src_a),
    .src_b   (src_b),
    .result  (comb_result),
    .illegal (comb_illegal)
  );

  // A finished result may be replaced in the same cycle it is consumed,
  // which is what gives back-to-back single-cycle throughput.
  assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign is_shift   = op_is_iterative(op_code);
  assign shamt      = src_b[SHAMT_W-1:0];
  assign shift_next = {shift_reg[XLEN-2:0], 1'b0};

  assign out_valid  = (state == ST_DONE);
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

  // FSM, shift datapath and output registers. Flush only redirects the
  // state; result/zero may keep stale values, which is harmless because
  // out_valid is low in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      count     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_SHIFT: begin
          shift_reg <= shift_next;
          count     <= count - 1'b1;
          // Last step: the count hits zero after this decrement.
          if (count == SHAMT_W'(1)) begin
            state     <= ST_DONE;
            result_q  <= shift_next;
            zero_q    <= (shift_next == '0);
            illegal_q <= 1'b0;
          end
        end

        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_shift) begin
              shift_reg <= src_a;
              count     <= shamt;
              illegal_q <= 1'b0;
              if (shamt == '0) begin
                state    <= ST_DONE;
                result_q <= src_a;
                zero_q   <= (src_a == '0);
              end else begin
                state <= ST_SHIFT;
              end
            end else begin
              state     <= ST_DONE;
              result_q  <= comb_result;
              zero_q    <= (comb_result == '0);
              illegal_q <= comb_illegal;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_alu_unit
// Self-checking bench for ex_alu_unit. Every accepted op gets its expected
// result, zero flag, illegal flag and due cycle pushed into a scoreboard.
// A monitor pops and compares whenever the unit presents a result.
// ---------------------------------------------------------------------------
module tb_ex_alu_unit;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [3:0]  op_code   = 4'b0000;
  logic [63:0] src_a     = '0;
  logic [63:0] src_b     = '0;
  logic        flush     = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        zero;
  logic        illegal_op;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total      = 0;
  int   bad        = 0;
  int   cyc        = 0;
  int   trk_c      = 0;
  logic rand_ready = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  always #5 clk = ~clk;

  ex_alu_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_code    (op_code),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the op means, plus when its result is due.
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input int c);
    exp_t e;
    int   lat;
    lat   = 1;
    e.ill = 1'b0;
    case (op)
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_SLL: begin
        e.res = a << b[5:0];
        lat   = int'(b[5:0]) + 1;
      end
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 64'd0);
    e.due  = c + lat;
    return e;
  endfunction

  // Stimulus tracker: sees each edge's accept and records the expectation.
  // The unit is ready exactly when nothing is owed to the consumer.
  always @(posedge clk) begin
    trk_c = cyc;
    cyc   = cyc + 1;
    if (!rst_n) begin
      sb.delete();
    end else begin
      check_output("in_ready", {63'd0, in_ready}, {63'd0, (sb.size() == 0)});
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(op_code, src_a, src_b, trk_c));
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_output("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          if (!prev_valid || prev_hs) check_output("latency", 64'(cyc), 64'(sb[0].due));
          check_output("result", result, sb[0].res);
          check_output("zero", {63'd0, zero}, {63'd0, sb[0].zero});
          check_output("illegal_op", {63'd0, illegal_op}, {63'd0, sb[0].ill});
          if (out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        check_output("late_result", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
    end
  end

  // Randomised backpressure for the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic apply_stimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int waited;
    bit done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          check_output("accept_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check_output("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [3:0]  ops [5];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR; ops[4] = OP_SLL;

    // Power-on reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("por_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("por_zero", {63'd0, zero}, 64'd1);
    check_output("por_result", result, 64'd0);
    check_output("por_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("por_illegal", {63'd0, illegal_op}, 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a long shift abandons it silently.
    apply_stimulus(OP_SLL, 64'h5, 64'd40);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_zero", {63'd0, zero}, 64'd1);
    check_output("rst_result", result, 64'd0);
    check_output("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops.
    apply_stimulus(OP_ADD, 64'd5, 64'd7);
    apply_stimulus(OP_SUB, 64'd7, 64'd7);
    apply_stimulus(OP_OR, 64'hF0, 64'h0F);
    wait_drain();

    // Shift latency, including the upper-bits-ignored and shamt=0/63 cases.
    apply_stimulus(OP_SLL, 64'd1, 64'h43);
    in_valid = 1'b0;
    @(negedge clk);
    check_output("in_ready_shift", {63'd0, in_ready}, 64'd0);
    wait_drain();
    apply_stimulus(OP_SLL, 64'h1234_5678_9ABC_DEF0, 64'h40);
    wait_drain();
    apply_stimulus(OP_SLL, 64'd1, 64'd63);
    wait_drain();

    // Backpressure: result held for 5 cycles, second op waits.
    out_ready = 1'b0;
    fork
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    apply_stimulus(OP_ADD, 64'd1, 64'd1);
    apply_stimulus(OP_ADD, 64'd10, 64'd20);
    wait_drain();

    // Flush part-way through a shift, then a normal add.
    apply_stimulus(OP_SLL, 64'hABC, 64'd20);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_output("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    apply_stimulus(OP_ADD, 64'd3, 64'd4);
    wait_drain();

    // Illegal code, then a legal op clears the flag.
    apply_stimulus(4'b1111, 64'hDEAD, 64'hBEEF);
    apply_stimulus(OP_AND, 64'hFF00, 64'h0FF0);
    wait_drain();

    // Random phase with backpressure, gaps and occasional flush.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) r_op = 4'($urandom_range(0, 15));
      else                           r_op = ops[$urandom_range(0, 4)];
      r_a = {$urandom, $urandom};
      r_b = ($urandom_range(0, 5) == 0) ? r_a : {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) flush = 1'b1;
      apply_stimulus(r_op, r_a, r_b);
      flush = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
